// File: rtl/mult_share_arb.sv
// Round-robin arbiter that serializes N_REQ requesters onto one shift-add multiplier.
// One job runs at a time: grant in IDLE, W add/shift iterations in MUL, hold result in RESP.
module mult_share_arb #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*W-1:0]       rsp_p,
  output logic                 busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
  } job_t;

  state_t         state, state_nxt;
  job_t           job;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant;
  logic           grant_vld;
  logic           hs;
  logic [W-1:0]   a_g, b_g;

  // Search starts just past the last winner; IDW-bit addition wraps modulo N_REQ.
  always_comb begin
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last_grant + IDW'(k);
      if (!grant_vld && req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  assign hs  = |(req_valid & req_ready);
  assign a_g = req_a[grant*W +: W];
  assign b_g = req_b[grant*W +: W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = MUL;
      MUL:     if (job.cnt == CW'(W-1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Fixed W iterations regardless of mplier going to zero early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job        <= '0;
      last_grant <= IDW'(N_REQ-1);
    end else begin
      case (state)
        IDLE: if (hs) begin
          job.mcand  <= {{W{1'b0}}, a_g};
          job.mplier <= b_g;
          job.acc    <= '0;
          job.cnt    <= '0;
          job.id     <= grant;
          last_grant <= grant;
        end
        MUL: begin
          if (job.mplier[0]) job.acc <= job.acc + job.mcand;
          job.mcand  <= job.mcand << 1;
          job.mplier <= job.mplier >> 1;
          job.cnt    <= job.cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_p     = job.acc;
  assign rsp_id    = job.id;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: directed scenarios plus a random soak,
// checked against a round-robin/latency reference model run in a negedge monitor.
module tb_mult_share_arb;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_p;
  logic           busy;

  mult_share_arb #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Reference model state
  int exp_id[$], exp_p[$];
  int mlast = N-1;
  bit in_flight = 0;
  int t = 0;
  int cyc = 0;
  bit prev_hold = 0;
  int prev_id = 0, prev_p = 0;
  int log_id[$], log_p[$], log_t[$], acc_t[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_id.delete(); exp_p.delete();
      in_flight = 0; t = 0; mlast = N-1; prev_hold = 0;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      logic [N-1:0] exp_rdy;
      logic [N-1:0] hsv;
      if (in_flight) t++;
      chk("rsp_valid", rsp_valid, (in_flight && t > W) ? 1 : 0);
      chk("busy", busy, in_flight);
      chk("ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
      exp_rdy = '0;
      if (!in_flight) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (mlast + k) % N;
          if (exp_rdy == 0 && req_valid[i]) exp_rdy[i] = 1'b1;
        end
      end
      chk("req_ready", req_ready, exp_rdy);
      if (prev_hold) begin
        chk("hold_id", rsp_id, prev_id);
        chk("hold_p", rsp_p, prev_p);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_id.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp act=%0d exp=none", rsp_id);
        end else begin
          chk("rsp_id", rsp_id, exp_id.pop_front());
          chk("rsp_p", rsp_p, exp_p.pop_front());
        end
        log_id.push_back(rsp_id); log_p.push_back(rsp_p); log_t.push_back(cyc);
        in_flight = 0;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_id = rsp_id; prev_p = rsp_p;
      hsv = req_valid & req_ready;
      if (hsv != 0) begin
        for (int i = 0; i < N; i++) if (hsv[i]) begin
          exp_id.push_back(i);
          exp_p.push_back(int'(req_a[i*W +: W]) * int'(req_b[i*W +: W]));
          mlast = i;
        end
        in_flight = 1; t = 0;
        acc_t.push_back(cyc);
      end
    end
  end

  // Requesters drop valid after the edge on which they were granted.
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = rst_n ? (req_valid & req_ready) : '0;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((req_valid != 0 || busy) && n < budget) begin tick(); n++; end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout act=%0d exp=<%0d", n, budget);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_p"}, rsp_p, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    #1 chk_reset_outs("reset");
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    log_id.delete(); log_p.delete(); log_t.delete(); acc_t.delete();
  endtask

  initial begin
    int n;
    // Basic single job
    do_reset();
    clear_logs();
    rsp_ready = 1'b1;
    set_req(0, 13, 11);
    wait_done(50);
    chk("t1_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      chk("t1_id", log_id[0], 0);
      chk("t1_p", log_p[0], 143);
    end

    // All four together, from reset priority
    do_reset();
    clear_logs();
    set_req(0, 15, 15); set_req(1, 0, 9); set_req(2, 1, 1); set_req(3, 7, 8);
    wait_done(100);
    chk("t2_count", log_id.size(), 4);
    if (log_id.size() == 4) begin
      int ep[4];
      ep = '{225, 0, 1, 56};
      for (int i = 0; i < 4; i++) begin
        chk("t2_id", log_id[i], i);
        chk("t2_p", log_p[i], ep[i]);
        if (i > 0) chk("t2_spacing", log_t[i] - log_t[i-1], W+2);
      end
    end

    // Wrap: after 2, contenders 0 and 3 resolve to 3 first
    clear_logs();
    set_req(2, 3, 5);
    wait_done(50);
    set_req(0, 2, 2); set_req(3, 4, 4);
    wait_done(50);
    chk("t3_count", log_id.size(), 3);
    if (log_id.size() == 3) begin
      chk("t3_id0", log_id[0], 2);
      chk("t3_id1", log_id[1], 3);
      chk("t3_id2", log_id[2], 0);
      chk("t3_p1", log_p[1], 16);
    end

    // Backpressure with requester 1 waiting
    clear_logs();
    rsp_ready = 1'b0;
    set_req(0, 12, 10);
    tick();
    set_req(1, 5, 3);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("t4_rsp_seen", rsp_valid, 1);
    repeat (5) tick();
    chk("t4_still_valid", rsp_valid, 1);
    chk("t4_ready_zero", req_ready, 0);
    rsp_ready = 1'b1;
    wait_done(50);
    chk("t4_count", log_id.size(), 2);
    if (log_id.size() == 2 && acc_t.size() == 2) begin
      chk("t4_p0", log_p[0], 120);
      chk("t4_id1", log_id[1], 1);
      chk("t4_p1", log_p[1], 15);
      chk("t4_regrant", acc_t[1] - log_t[0], 1);
    end

    // Reset mid-MUL discards the job
    do_reset();
    clear_logs();
    set_req(1, 9, 6);
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    tick();
    #1 rst_n = 1'b0;
    #1 chk_reset_outs("async");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t5_no_rsp", log_id.size(), 0);
    set_req(1, 9, 6);
    wait_done(50);
    chk("t5_count", log_id.size(), 1);
    if (log_id.size() == 1) begin
      chk("t5_id", log_id[0], 1);
      chk("t5_p", log_p[0], 54);
    end

    // Random soak
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) set_req(i, $urandom_range(15), $urandom_range(15));
        end else if ($urandom_range(15) == 0 && !req_ready[i]) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(9) < 7);
      tick();
    end
    rsp_ready = 1'b1;
    wait_done(200);
    tick();
    chk("soak_drained", exp_id.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
